moore_1010_frame_tx: RTL and testbench
======================================

// Module: moore_1010_frame_tx
// PURPOSE
//   Framed serial transmitter: emits sync pattern 1010 followed by a parallel payload, serialized MSB-first.
//   Produces the bit stream that the team's overlapping 1010 Moore detector consumes.
//   The detector marks frame boundaries on the sync pattern.
//   Sits between a parallel producer (valid/ready handshake) and the 1-bit serial line.
// PARAMETERS
//   DATA_W    8        payload width in bits (>=1)
//   SYNC_PAT  4'b1010  sync pattern, sent MSB-first
//   SYNC_LEN  4        sync pattern length in bits (width of SYNC_PAT)
//   PARITY_EN 1        1: append even-parity bit (XOR of payload) after payload; 0: none
//   GAP_CYC   2        idle cycles (sout=IDLE_BIT) inserted after each frame (>=0)
//   IDLE_BIT  1'b0     line level while idle / in gap
// PORTS
//   clk         in   1       clock, rising edge
//   rst         in   1       asynchronous, active-high reset
//   data_in     in   DATA_W  payload word; sampled only on accept
//   data_valid  in   1       producer has a word
//   data_ready  out  1       block can accept a word this cycle
//   sout        out  1       serial output, registered (Moore)
//   busy        out  1       1 while in SYNC/DATA/PAR/GAP
//   frame_done  out  1       1-cycle pulse, coincident with the last frame bit on sout
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, sout=IDLE_BIT, busy=0, frame_done=0, data_ready=1, counters=0.
//   Accept: rising edge with data_valid && data_ready. data_in is latched into the shift register.
//     Later changes on data_in are ignored until the next accept.
//   FSM states:
//     IDLE -(accept)-> SYNC; otherwise stays IDLE.
//     SYNC: SYNC_LEN cycles -> DATA.
//     DATA: DATA_W cycles -> PAR if PARITY_EN, else GAP.
//     PAR: 1 cycle -> GAP.
//     GAP: GAP_CYC cycles -> IDLE. GAP_CYC=0 means GAP is skipped.
//   Timing:
//     sout, busy and frame_done are registered.
//     Accept at edge N: sout = SYNC_PAT[SYNC_LEN-1] during cycle N..N+1.
//     First payload bit (data_in[DATA_W-1]) appears at edge N+SYNC_LEN.
//     Frame length F = SYNC_LEN+DATA_W+PARITY_EN; last frame bit is driven at edge N+F-1.
//   Outputs by state:
//     GAP/IDLE: sout = IDLE_BIT.
//     busy: 1 from edge N to the end of GAP.
//     frame_done: 1 exactly for the cycle carrying the last frame bit.
//   data_ready:
//     Equals (state==IDLE).
//     Exception: when GAP_CYC==0, data_ready is also 1 during the last-frame-bit cycle.
//     An accept there starts the next sync bit on the immediately following edge, giving a gapless stream.
//   Parity is computed on the latched word, not on live data_in.
//   data_valid while busy (and not ready) is held off; no word is dropped or latched.
//   Reset mid-frame: the frame is aborted immediately (async).
//     sout=IDLE_BIT, busy=0, no frame_done; the partial frame is not resumed after reset.
//   Counters are sized for max(SYNC_LEN, DATA_W, GAP_CYC) and wrap only via state exit, never by overflow.
//   Payload bits are sent verbatim; no bit stuffing. A payload containing 1010 may alias sync downstream.
// TESTING (defaults unless stated)
//   1. Reset, then idle 5 cycles -> sout=0, busy=0, data_ready=1, frame_done=0.
//   2. Accept 0xA5 -> sout = 1,0,1,0, 1,0,1,0,0,1,0,1, 0, then 0,0.
//      frame_done high on the parity-bit cycle; data_ready returns 2 cycles later.
//   3. Accept 0x01 with PARITY_EN=1 -> parity bit 1.
//      With PARITY_EN=0 -> 12-bit frame; frame_done on the payload LSB.
//   4. GAP_CYC=0, data_valid held high with 0xFF then 0x00 -> two 13-bit frames back-to-back.
//      No idle bit between them; data_ready is 1 only on each last-bit cycle.
//   5. Change data_in every cycle during a frame; hold data_valid=1 while busy.
//      -> Payload equals the word captured at accept; exactly one accept per frame.
//   6. Assert rst at the 3rd payload bit -> sout=0 and busy=0 asynchronously, no frame_done.
//      After release, a new accept of 0x3C sends a complete, correct frame.

Source files
------------

// File: rtl/moore_1010_frame_tx_if.sv
// Producer-side handshake and serial-line bundle for the framed 1010 transmitter.
// The producer holds the master side; the transmitter holds the slave side.
interface moore_1010_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic              sout;
    logic              busy;
    logic              frame_done;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  sout,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output sout,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/moore_1010_frame_tx.sv
// Framed serial transmitter: sync pattern, payload MSB-first, optional even parity,
// then an idle gap. All line outputs are registered (Moore).
module moore_1010_frame_tx #(
    parameter int                  DATA_W    = 8,
    parameter int                  SYNC_LEN  = 4,
    parameter logic [SYNC_LEN-1:0] SYNC_PAT  = 4'b1010,
    parameter bit                  PARITY_EN = 1'b1,
    parameter int                  GAP_CYC   = 2,
    parameter logic                IDLE_BIT  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    moore_1010_frame_tx_if.slave bus
);
    localparam int FW   = SYNC_LEN + DATA_W;
    localparam int M1   = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
    localparam int CMAX = (M1 > GAP_CYC) ? M1 : GAP_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] C_SYNC_LAST = CW'(SYNC_LEN - 1);
    localparam logic [CW-1:0] C_DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] C_DATA_PEN  =
        CW'((DATA_W >= 2) ? DATA_W - 2 : 0);
    localparam logic [CW-1:0] C_GAP_LAST  =
        CW'((GAP_CYC >= 1) ? GAP_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_PAR,
        S_GAP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [FW-1:0]   r_shift;
    logic            r_par;
    logic            r_sout;
    logic            r_busy;
    logic            r_done;

    logic            w_ready;
    logic            w_accept;
    logic            w_frame_end;
    logic [FW-1:0]   w_load;

    // Without a gap the next word may be taken on the last-bit cycle.
    assign w_ready = (r_state == S_IDLE) ||
                     ((GAP_CYC == 0) && r_done);
    assign w_accept = bus.data_valid && w_ready;
    assign w_load = {SYNC_PAT, bus.data_in};
    assign w_frame_end = (r_state == S_PAR) ||
                         ((r_state == S_DATA) &&
                          (r_cnt == C_DATA_LAST) && !PARITY_EN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_sout  <= IDLE_BIT;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_accept) begin
            // Sync and payload share one shift register.
            r_state <= S_SYNC;
            r_cnt   <= '0;
            r_shift <= {w_load[FW-2:0], 1'b0};
            r_par   <= ^bus.data_in;
            r_sout  <= w_load[FW-1];
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else if (w_frame_end) begin
            r_cnt  <= '0;
            r_sout <= IDLE_BIT;
            r_done <= 1'b0;
            if (GAP_CYC > 0) begin
                r_state <= S_GAP;
                r_busy  <= 1'b1;
            end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_sout <= IDLE_BIT;
                end
                S_SYNC: begin
                    r_sout  <= r_shift[FW-1];
                    r_shift <= {r_shift[FW-2:0], 1'b0};
                    if (r_cnt == C_SYNC_LAST) begin
                        r_state <= S_DATA;
                        r_cnt   <= '0;
                        r_done  <= !PARITY_EN && (DATA_W == 1);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == C_DATA_LAST) begin
                        r_state <= S_PAR;
                        r_cnt   <= '0;
                        r_sout  <= r_par;
                        r_done  <= 1'b1;
                    end else begin
                        r_sout  <= r_shift[FW-1];
                        r_shift <= {r_shift[FW-2:0], 1'b0};
                        r_cnt   <= r_cnt + 1'b1;
                        r_done  <= !PARITY_EN &&
                                   (r_cnt == C_DATA_PEN);
                    end
                end
                S_GAP: begin
                    r_sout <= IDLE_BIT;
                    if (r_cnt == C_GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_sout  <= IDLE_BIT;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_ready = w_ready;
    assign bus.sout       = r_sout;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;
endmodule

// File: tb/tb_moore_1010_frame_tx.sv
// Scoreboard bench: three transmitter configs (default, no parity, no gap)
// checked cycle by cycle against frames modelled from the accepted words.
module tb_moore_1010_frame_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] din [3];
    logic       vld [3];
    logic [3:0] ob  [3];

    moore_1010_frame_tx_if #(.DATA_W(8)) if0 ();
    moore_1010_frame_tx_if #(.DATA_W(8)) if1 ();
    moore_1010_frame_tx_if #(.DATA_W(8)) if2 ();

    assign if0.data_in = din[0];
    assign if0.data_valid = vld[0];
    assign if1.data_in = din[1];
    assign if1.data_valid = vld[1];
    assign if2.data_in = din[2];
    assign if2.data_valid = vld[2];

    // {sout, frame_done, busy, data_ready}
    assign ob[0] = {if0.sout, if0.frame_done, if0.busy, if0.data_ready};
    assign ob[1] = {if1.sout, if1.frame_done, if1.busy, if1.data_ready};
    assign ob[2] = {if2.sout, if2.frame_done, if2.busy, if2.data_ready};

    moore_1010_frame_tx dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    moore_1010_frame_tx #(.PARITY_EN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave)
    );
    moore_1010_frame_tx #(.GAP_CYC(0)) dut2 (
        .clk(clk), .rst(rst), .bus(if2.slave)
    );

    typedef struct packed {
        logic s;
        logic d;
        logic b;
        logic r;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   idx;

    task automatic push_frame(input logic [7:0] w, input bit pen,
                              input int gap);
        logic [11:0] f;
        bit last;
        f = {4'b1010, w};
        for (int i = 0; i < 12; i++) begin
            last = !pen && (i == 11);
            sb.push_back('{f[11-i], last, 1'b1, (gap == 0) && last});
        end
        if (pen)
            sb.push_back('{^w, 1'b1, 1'b1, gap == 0});
        for (int g = 0; g < gap; g++)
            sb.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
    endtask

    task automatic start(input int d, input logic [7:0] w);
        @(negedge clk);
        din[d] = w;
        vld[d] = 1'b1;
        @(negedge clk);
        vld[d] = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (ob[d] !== 4'b0001) begin
                    errors++;
                    $display("FAIL reset dut%0d cyc%0d: got %b want 0001",
                             d, c, ob[d]);
                end
            end
        end
    endtask

    task automatic test_a5;
        start(0, 8'hA5);
        push_frame(8'hA5, 1'b1, 2);
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (ob[0] !== e) begin
                errors++;
                $display("FAIL a5 bit%0d: got %b want %b", idx, ob[0], e);
            end
            idx++;
            @(negedge clk);
        end
        checks++;
        if (ob[0] !== 4'b0001) begin
            errors++;
            $display("FAIL a5 idle: got %b want 0001", ob[0]);
        end
    endtask

    task automatic test_parity;
        for (int d = 0; d < 2; d++) begin
            start(d, 8'h01);
            push_frame(8'h01, d == 0, 2);
            idx = 0;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (ob[d] !== e) begin
                    errors++;
                    $display("FAIL parity dut%0d bit%0d: got %b want %b",
                             d, idx, ob[d], e);
                end
                idx++;
                @(negedge clk);
            end
            checks++;
            if (ob[d] !== 4'b0001) begin
                errors++;
                $display("FAIL parity dut%0d idle: got %b want 0001",
                         d, ob[d]);
            end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        din[2] = 8'hFF;
        vld[2] = 1'b1;
        @(negedge clk);
        din[2] = 8'h00;
        push_frame(8'hFF, 1'b1, 0);
        push_frame(8'h00, 1'b1, 0);
        idx = 0;
        while (sb.size() > 0) begin
            if (idx == 13) vld[2] = 1'b0;
            e = sb.pop_front();
            checks++;
            if (ob[2] !== e) begin
                errors++;
                $display("FAIL b2b bit%0d: got %b want %b", idx, ob[2], e);
            end
            idx++;
            @(negedge clk);
        end
        checks++;
        if (ob[2] !== 4'b0001) begin
            errors++;
            $display("FAIL b2b idle: got %b want 0001", ob[2]);
        end
    endtask

    task automatic test_hold_data;
        @(negedge clk);
        din[0] = 8'h96;
        vld[0] = 1'b1;
        @(negedge clk);
        push_frame(8'h96, 1'b1, 2);
        sb.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
        push_frame(8'h5A, 1'b1, 2);
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (ob[0] !== e) begin
                errors++;
                $display("FAIL hold bit%0d: got %b want %b", idx, ob[0], e);
            end
            if (idx < 15) din[0] = 8'($urandom);
            if (idx == 15) din[0] = 8'h5A;
            if (idx == 16) vld[0] = 1'b0;
            idx++;
            @(negedge clk);
        end
        checks++;
        if (ob[0] !== 4'b0001) begin
            errors++;
            $display("FAIL hold idle: got %b want 0001", ob[0]);
        end
    endtask

    task automatic test_reset_mid;
        start(0, 8'hC3);
        push_frame(8'hC3, 1'b1, 2);
        for (int i = 0; i < 6; i++) begin
            e = sb.pop_front();
            checks++;
            if (ob[0] !== e) begin
                errors++;
                $display("FAIL rmid pre bit%0d: got %b want %b", i, ob[0], e);
            end
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ob[0] !== 4'b0001) begin
            errors++;
            $display("FAIL rmid async: got %b want 0001", ob[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ob[0] !== 4'b0001) begin
            errors++;
            $display("FAIL rmid held: got %b want 0001", ob[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (ob[0] !== 4'b0001) begin
            errors++;
            $display("FAIL rmid noresume: got %b want 0001", ob[0]);
        end
        start(0, 8'h3C);
        push_frame(8'h3C, 1'b1, 2);
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (ob[0] !== e) begin
                errors++;
                $display("FAIL rmid 3c bit%0d: got %b want %b",
                         idx, ob[0], e);
            end
            idx++;
            @(negedge clk);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            din[d] = 8'h00;
            vld[d] = 1'b0;
        end
        test_reset;
        test_a5;
        test_parity;
        test_back_to_back;
        test_hold_data;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
